// File: rtl/encoder_blk_sched.sv
`default_nettype none
// ============================================================================
// Module   : encoder_blk_sched
// Purpose  : Schedules encoder blocks. Pops one meta byte per block, validates
//            it, waits until the data FIFO holds a full block (132 or 768
//            bytes), pulses the encoder start and then waits for the encoder
//            to finish under a watchdog.
// Ports    : clk, reset                 - clock, async active-high reset
//            en                         - allow starting new blocks
//            meta_empty, meta_q         - meta FIFO status / output byte
//            meta_rdreq                 - meta FIFO pop (combinational)
//            data_usedw, data_full      - data FIFO fill level
//            computation_done           - encoder finished pulse
//            blk_ready, blk_size_sel    - encoder start pulse / block size
//            busy                       - scheduler not idle
//            meta_err, timeout_err      - error pulses
//            blk_count                  - completed block counter (wraps)
// Revision : 1.0 - initial release
// ============================================================================
module encoder_blk_sched #(
    parameter int USEDW_W     = 10,
    parameter int TIMEOUT_CYC = 20000,
    parameter int CNT_W       = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    input  logic               meta_empty,
    input  logic [7:0]         meta_q,
    input  logic [USEDW_W-1:0] data_usedw,
    input  logic               data_full,
    input  logic               computation_done,
    output logic               meta_rdreq,
    output logic               blk_ready,
    output logic               blk_size_sel,
    output logic               busy,
    output logic               meta_err,
    output logic               timeout_err,
    output logic [CNT_W-1:0]   blk_count
);

    localparam int WD_W  = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    // Compare width must hold both the fill count and the 768-byte threshold.
    localparam int CMP_W = (USEDW_W > 10) ? USEDW_W : 10;

    localparam logic [2:0] c_st_idle      = 3'd0;
    localparam logic [2:0] c_st_meta_rd   = 3'd1;
    localparam logic [2:0] c_st_meta_chk  = 3'd2;
    localparam logic [2:0] c_st_wait_data = 3'd3;
    localparam logic [2:0] c_st_start     = 3'd4;
    localparam logic [2:0] c_st_run       = 3'd5;

    localparam logic [WD_W-1:0]  c_wd_last    = WD_W'(TIMEOUT_CYC - 1);
    localparam logic [CMP_W-1:0] c_need_small = CMP_W'(132);
    localparam logic [CMP_W-1:0] c_need_large = CMP_W'(768);

    logic [2:0]       r_state;
    logic [2:0]       w_state_nxt;
    logic [WD_W-1:0]  r_wd;
    logic             r_blk_size_sel;
    logic             r_blk_ready;
    logic             r_busy;
    logic             r_meta_err;
    logic             r_timeout_err;
    logic [CNT_W-1:0] r_blk_count;

    logic             w_meta_ok;
    logic [CMP_W-1:0] w_need;
    logic             w_data_avail;
    logic             w_wd_expired;

    logic             w_blk_ready_nxt;
    logic             w_busy_nxt;
    logic             w_meta_err_nxt;
    logic             w_timeout_err_nxt;
    logic             w_count_inc;
    logic             w_size_latch;

    // Only 0x00 and 0x01 are legal meta bytes.
    assign w_meta_ok    = (meta_q[7:1] == 7'd0);
    assign w_need       = r_blk_size_sel ? c_need_large : c_need_small;
    // data_usedw reads 0 when the FIFO is completely full, hence data_full.
    assign w_data_avail = data_full || (CMP_W'(data_usedw) >= w_need);
    assign w_wd_expired = (r_wd == c_wd_last);

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle: begin
                if (en && !meta_empty) begin
                    w_state_nxt = c_st_meta_rd;
                end
            end
            // Meta byte appears on meta_q one cycle after the pop.
            c_st_meta_rd: begin
                w_state_nxt = c_st_meta_chk;
            end
            c_st_meta_chk: begin
                w_state_nxt = w_meta_ok ? c_st_wait_data : c_st_idle;
            end
            // en is deliberately ignored: a popped block is always finished.
            c_st_wait_data: begin
                if (w_data_avail) begin
                    w_state_nxt = c_st_start;
                end
            end
            c_st_start: begin
                w_state_nxt = c_st_run;
            end
            c_st_run: begin
                if (computation_done || w_wd_expired) begin
                    w_state_nxt = c_st_idle;
                end
            end
            default: begin
                w_state_nxt = c_st_idle;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Output logic: next values of the registered outputs, plus the meta pop
    // which must be combinational so the FIFO sees it in the IDLE cycle.
    // ------------------------------------------------------------------------
    always_comb begin
        meta_rdreq        = !reset && (r_state == c_st_idle) && en && !meta_empty;
        w_blk_ready_nxt   = (w_state_nxt == c_st_start);
        w_busy_nxt        = (w_state_nxt != c_st_idle);
        w_meta_err_nxt    = (r_state == c_st_meta_chk) && !w_meta_ok;
        w_size_latch      = (r_state == c_st_meta_chk) && w_meta_ok;
        w_count_inc       = (r_state == c_st_run) && computation_done;
        // Done in the expiry cycle wins over the watchdog.
        w_timeout_err_nxt = (r_state == c_st_run) && !computation_done && w_wd_expired;
    end

    // ------------------------------------------------------------------------
    // Registered outputs and watchdog
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_blk_ready    <= 1'b0;
            r_busy         <= 1'b0;
            r_meta_err     <= 1'b0;
            r_timeout_err  <= 1'b0;
            r_blk_size_sel <= 1'b0;
            r_blk_count    <= '0;
            r_wd           <= '0;
        end else begin
            r_blk_ready   <= w_blk_ready_nxt;
            r_busy        <= w_busy_nxt;
            r_meta_err    <= w_meta_err_nxt;
            r_timeout_err <= w_timeout_err_nxt;
            if (w_size_latch) begin
                r_blk_size_sel <= meta_q[0];
            end
            if (w_count_inc) begin
                r_blk_count <= r_blk_count + CNT_W'(1);
            end
            // Watchdog reads 0 in START and k in the k-th RUN cycle, so the
            // expiry decision lands TIMEOUT_CYC-1 cycles after blk_ready.
            if (w_state_nxt == c_st_start) begin
                r_wd <= '0;
            end else if (w_state_nxt == c_st_run) begin
                r_wd <= r_wd + WD_W'(1);
            end
        end
    end

    assign blk_ready    = r_blk_ready;
    assign blk_size_sel = r_blk_size_sel;
    assign busy         = r_busy;
    assign meta_err     = r_meta_err;
    assign timeout_err  = r_timeout_err;
    assign blk_count    = r_blk_count;

endmodule
`default_nettype wire

// File: tb/tb_encoder_blk_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_encoder_blk_sched
// Purpose  : Self-checking bench for encoder_blk_sched. A block-timeline
//            model predicts every output each cycle; directed scenarios add
//            hand-computed literal expectations. A second instance with
//            default parameters runs the long-latency nominal block.
// Revision : 1.0 - initial release
// ============================================================================
module tb_encoder_blk_sched;

    localparam int TB_TIMEOUT = 16;
    localparam int TB_CNT_W   = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- main DUT (short watchdog, narrow counter) -------------
    logic                reset = 1'b1;
    logic                en = 1'b0;
    logic                meta_empty;
    logic [7:0]          meta_q = 8'h00;
    logic [9:0]          data_usedw = '0;
    logic                data_full = 1'b0;
    logic                computation_done = 1'b0;
    logic                meta_rdreq, blk_ready, blk_size_sel, busy, meta_err, timeout_err;
    logic [TB_CNT_W-1:0] blk_count;

    encoder_blk_sched #(
        .USEDW_W(10), .TIMEOUT_CYC(TB_TIMEOUT), .CNT_W(TB_CNT_W)
    ) dut (
        .clk(clk), .reset(reset), .en(en), .meta_empty(meta_empty), .meta_q(meta_q),
        .data_usedw(data_usedw), .data_full(data_full), .computation_done(computation_done),
        .meta_rdreq(meta_rdreq), .blk_ready(blk_ready), .blk_size_sel(blk_size_sel),
        .busy(busy), .meta_err(meta_err), .timeout_err(timeout_err), .blk_count(blk_count)
    );

    // ---------------- default-parameter DUT ---------------------------------
    logic        d_en = 1'b0, d_empty = 1'b1, d_full = 1'b0, d_done = 1'b0;
    logic [7:0]  d_q = 8'h00;
    logic [9:0]  d_usedw = '0;
    logic        d_rdreq, d_ready, d_sel, d_busy, d_merr, d_terr;
    logic [15:0] d_cnt;

    encoder_blk_sched dut_def (
        .clk(clk), .reset(reset), .en(d_en), .meta_empty(d_empty), .meta_q(d_q),
        .data_usedw(d_usedw), .data_full(d_full), .computation_done(d_done),
        .meta_rdreq(d_rdreq), .blk_ready(d_ready), .blk_size_sel(d_sel),
        .busy(d_busy), .meta_err(d_merr), .timeout_err(d_terr), .blk_count(d_cnt)
    );

    // ---------------- meta FIFO (normal mode: q updates after pop) ----------
    logic [7:0] meta_mem [0:255];
    int meta_wr = 0;
    int meta_rd = 0;
    assign meta_empty = (meta_wr == meta_rd);

    always @(posedge clk) begin
        if (meta_rdreq && !meta_empty) begin
            meta_q  <= meta_mem[meta_rd[7:0]];
            meta_rd <= meta_rd + 1;
        end
    end

    task automatic push(input logic [7:0] b);
        meta_mem[meta_wr[7:0]] = b;
        meta_wr++;
    endtask

    // ---------------- scoreboard counters ------------------------------------
    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, want %0h (t=%0t)", nm, act, exp, $time);
    endtask

    // ---------------- behavioural model --------------------------------------
    // A block is tracked by its age since the meta pop; once started, by the
    // number of cycles since blk_ready. rdy/merr/terr are the pulses the DUT
    // must show in the cycle after the decision.
    typedef struct packed {
        logic        act;
        logic        started;
        logic [1:0]  age;
        logic        sel;
        logic [31:0] run;
        logic [TB_CNT_W-1:0] cnt;
        logic        rdy;
        logic        merr;
        logic        terr;
    } mstate_t;

    function automatic mstate_t model_step(input mstate_t s, input logic v_en, input logic v_empty,
                                           input logic [7:0] v_q, input logic [9:0] v_used,
                                           input logic v_full, input logic v_done);
        mstate_t n = s;
        n.rdy  = 1'b0;
        n.merr = 1'b0;
        n.terr = 1'b0;
        if (!s.act) begin
            if (v_en && !v_empty) begin
                n.act = 1'b1; n.started = 1'b0; n.age = 2'd1;
            end
        end else if (!s.started) begin
            if (s.age == 2'd1) begin
                n.age = 2'd2;
            end else if (s.age == 2'd2) begin
                if (v_q[7:1] != 7'd0) begin
                    n.merr = 1'b1; n.act = 1'b0;
                end else begin
                    n.sel = v_q[0]; n.age = 2'd3;
                end
            end else if (v_full || int'(v_used) >= (s.sel ? 768 : 132)) begin
                n.rdy = 1'b1; n.started = 1'b1; n.run = 0;
            end
        end else begin
            if (s.run >= 1 && v_done) begin
                n.cnt = s.cnt + 1'b1; n.act = 1'b0;
            end else if (s.run == TB_TIMEOUT - 1) begin
                n.terr = 1'b1; n.act = 1'b0;
            end
            n.run = s.run + 1;
        end
        return n;
    endfunction

    mstate_t m = '0;
    always @(posedge clk or posedge reset) begin
        if (reset) m <= '0;
        else       m <= model_step(m, en, meta_empty, meta_q, data_usedw, data_full, computation_done);
    end

    // ---------------- per-cycle compare --------------------------------------
    initial begin
        forever begin
            @(negedge clk);
            chk("meta_rdreq",   {31'd0, meta_rdreq},   {31'd0, !reset && !m.act && en && !meta_empty});
            chk("blk_ready",    {31'd0, blk_ready},    {31'd0, m.rdy});
            chk("blk_size_sel", {31'd0, blk_size_sel}, {31'd0, m.sel});
            chk("busy",         {31'd0, busy},         {31'd0, m.act});
            chk("meta_err",     {31'd0, meta_err},     {31'd0, m.merr});
            chk("timeout_err",  {31'd0, timeout_err},  {31'd0, m.terr});
            chk("blk_count",    32'(blk_count),        32'(m.cnt));
        end
    end

    // Pulse observation counters used by the literal checks.
    int n_rdy = 0, n_merr = 0, n_terr = 0, n_rdreq = 0;
    always @(negedge clk) begin
        if (blk_ready)   n_rdy++;
        if (meta_err)    n_merr++;
        if (timeout_err) n_terr++;
        if (meta_rdreq)  n_rdreq++;
    end

    // ---------------- stimulus helpers ---------------------------------------
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_ready(input string nm);
        int lat = 0;
        while (blk_ready !== 1'b1 && lat < 2000) begin
            tick();
            lat++;
        end
        chk(nm, {31'd0, blk_ready}, 32'd1);
    endtask

    // Pulse done in the k-th cycle after the blk_ready cycle, then settle.
    task automatic finish_block(input int k);
        repeat (k) tick();
        computation_done = 1'b1;
        tick();
        computation_done = 1'b0;
        tick();
    endtask

    // ---------------- directed scenarios -------------------------------------
    initial begin
        int n, r0, e0, t0, q0;
        logic [TB_CNT_W-1:0] c0;

        repeat (3) tick();
        chk("rst_busy",  {31'd0, busy}, 32'd0);
        chk("rst_count", 32'(blk_count), 32'd0);
        chk("rst_rdreq", {31'd0, d_rdreq}, 32'd0);
        reset = 1'b0;

        // Nominal block on the default instance: done 50 cycles after start.
        d_en = 1'b1; d_usedw = 10'd132; d_empty = 1'b0;
        #1;
        chk("def_rdreq", {31'd0, d_rdreq}, 32'd1);
        tick();
        d_empty = 1'b1;
        n = 1;
        while (!d_ready && n < 20) begin tick(); n++; end
        chk("def_ready_latency", n, 32'd4);
        chk("def_size_sel", {31'd0, d_sel}, 32'd0);
        d_en = 1'b0;
        repeat (50) tick();
        d_done = 1'b1;
        tick();
        d_done = 1'b0;
        tick();
        chk("def_count", 32'(d_cnt), 32'd1);
        chk("def_idle", {31'd0, d_busy}, 32'd0);

        // Large block: ramp fill count; start only after it reaches 768.
        en = 1'b1;
        push(8'h01);
        r0 = n_rdy;
        for (int u = 0; u < 768; u++) begin
            data_usedw = 10'(u);
            tick();
        end
        chk("ramp_no_ready", n_rdy - r0, 32'd0);
        data_usedw = 10'd768;
        tick();
        chk("ready_at_768", {31'd0, blk_ready}, 32'd1);
        chk("size_large", {31'd0, blk_size_sel}, 32'd1);
        finish_block(3);
        chk("count_after_large", 32'(blk_count), 32'd1);

        // Full FIFO with wrapped fill count of 0 also starts a block.
        data_usedw = 10'd0; data_full = 1'b1;
        push(8'h01);
        wait_ready("full_start");
        data_full = 1'b0;
        finish_block(3);
        chk("count_after_full", 32'(blk_count), 32'd2);

        // Illegal meta byte dropped, next byte handled normally.
        data_usedw = 10'd132;
        r0 = n_rdy; e0 = n_merr;
        push(8'h82);
        push(8'h00);
        repeat (6) tick();
        chk("merr_pulses", n_merr - e0, 32'd1);
        chk("merr_no_ready", n_rdy - r0, 32'd0);
        wait_ready("after_err_ready");
        chk("size_small", {31'd0, blk_size_sel}, 32'd0);
        finish_block(4);
        chk("count_after_err", 32'(blk_count), 32'd3);

        // Watchdog: no done -> timeout 16 cycles after blk_ready.
        data_usedw = 10'd200;
        push(8'h00);
        wait_ready("to_ready");
        c0 = blk_count;
        n = 0;
        while (!timeout_err && n < 100) begin tick(); n++; end
        chk("timeout_latency", n, 32'd16);
        chk("timeout_count", 32'(blk_count), 32'(c0));

        // Done in the expiry cycle: counts, no timeout.
        t0 = n_terr;
        push(8'h00);
        wait_ready("exp_ready");
        finish_block(15);
        chk("exp_done_count", 32'(blk_count), 32'(c0 + 1'b1));
        chk("exp_no_timeout", n_terr - t0, 32'd0);

        // Reset mid-RUN abandons the block; later done is ignored.
        push(8'h00);
        wait_ready("rst_blk_ready");
        tick(); tick();
        reset = 1'b1;
        tick();
        r0 = n_rdy; e0 = n_merr; t0 = n_terr;
        reset = 1'b0;
        computation_done = 1'b1;
        tick();
        computation_done = 1'b0;
        repeat (20) tick();
        chk("rst_mid_count", 32'(blk_count), 32'd0);
        chk("rst_mid_no_pulse", (n_rdy - r0) + (n_merr - e0) + (n_terr - t0), 32'd0);

        // en dropped during RUN: block completes, no new pop until en returns.
        push(8'h00);
        wait_ready("en_blk_ready");
        en = 1'b0;
        push(8'h00);
        q0 = n_rdreq;
        finish_block(5);
        repeat (8) tick();
        chk("en_low_count", 32'(blk_count), 32'd1);
        chk("en_low_no_pop", n_rdreq - q0, 32'd0);
        en = 1'b1;
        #1;
        chk("en_high_pop", {31'd0, meta_rdreq}, 32'd1);
        wait_ready("en_high_ready");
        finish_block(5);

        // Three queued meta bytes run back to back.
        r0 = n_rdy;
        repeat (3) push(8'h00);
        for (int i = 0; i < 3; i++) begin
            wait_ready("queued_ready");
            finish_block(3);
        end
        chk("queued_pulses", n_rdy - r0, 32'd3);
        chk("queued_count", 32'(blk_count), 32'd5);

        // Drive the counter to its top value, then one more block wraps it.
        repeat (10) push(8'h00);
        for (int i = 0; i < 10; i++) begin
            wait_ready("fill_ready");
            finish_block(2);
        end
        chk("count_top", 32'(blk_count), 32'd15);
        push(8'h00);
        wait_ready("wrap_ready");
        finish_block(2);
        chk("count_wrap", 32'(blk_count), 32'd0);

        repeat (3) tick();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
